cv32e40p_fetch_sequencer: RTL
=============================

Name: cv32e40p_fetch_sequencer

Overview:
Sequences instruction fetches from the OBI-style instruction memory port and feeds the IF stage's fetch_valid/instruction inputs through a small response FIFO.
Tracks outstanding transactions and discards in-flight responses on a branch redirect.
Latches bus errors as a failed fetch and stops fetching until the next redirect.
Sits between the instruction memory interface and the IF-ID pipeline registers; the IF stage pops an entry when it advances (fetch_ready_i).

Parameters:
DEPTH, 2, FIFO entries and the maximum number of outstanding bus transactions (combined budget); legal values 2..4.
BOOT_ADDR, 32'h0000_0080, fetch address after reset until the first branch.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
fetch_enable_i  input  1  level; 1 allows new bus requests.
branch_i  input  1  redirect pulse; flush and restart at branch_addr_i.
branch_addr_i  input  32  redirect target; bits [1:0] ignored (word aligned).
fetch_ready_i  input  1  IF consumes the FIFO head this cycle.
fetch_valid_o  output  1  FIFO head valid.
fetch_rdata_o  output  32  FIFO head instruction word.
fetch_addr_o  output  32  FIFO head word address.
fetch_failed_o  output  1  FIFO head carries a bus error.
instr_req_o  output  1  bus request.
instr_addr_o  output  32  bus address, word aligned.
instr_gnt_i  input  1  bus grant.
instr_rvalid_i  input  1  bus response valid.
instr_rdata_i  input  32  bus response data.
instr_err_i  input  1  bus response error, qualified by instr_rvalid_i.
busy_o  output  1  outstanding != 0 or instr_req_o.

Behaviour:
- Reset values: instr_req_o=0, instr_addr_o=BOOT_ADDR, fetch_valid_o=0, fetch_rdata_o=0, fetch_addr_o=0, fetch_failed_o=0, busy_o=0. Internal state: FIFO empty, outstanding=0, drop=0, FSM=IDLE. Reset mid-transaction abandons all state; late rvalids after reset are counted as nothing and ignored when outstanding=0.
- FSM states:
  - IDLE: no request.
    - Goes to ISSUE when fetch_enable_i=1 and (outstanding + fifo_count) < DEPTH.
  - ISSUE: instr_req_o=1, with instr_addr_o held stable until grant.
    - On instr_gnt_i: outstanding increments and the address advances by 4.
    - Stays in ISSUE if the budget still allows after this grant and fetch_enable_i=1; otherwise goes to IDLE.
    - The request is never withdrawn before grant, even if fetch_enable_i drops or branch_i arrives.
  - FAILED: entered when an error response is written into the FIFO.
    - No new requests issue in this state. Leaves only on branch_i.
- Response handling:
  - Each instr_rvalid_i decrements outstanding.
  - If drop>0, the response is discarded and drop decrements.
  - Otherwise the response is pushed as {rdata, address, err}. Per-entry addresses come from an issue-order address queue.
- Output latency: one cycle from rvalid to fetch_valid_o; no bypass path.
- Pop: when fetch_valid_o & fetch_ready_i. A simultaneous push and pop is legal at any occupancy. Overflow is impossible by the budget rule; an overflow in simulation is an assertion failure.
- Branch (branch_i=1) takes priority over every other event in the same cycle:
  - Flushes the FIFO, including an entry being popped or pushed that cycle.
  - drop <= outstanding + (gnt this cycle) - (rvalid this cycle).
  - The next address becomes {branch_addr_i[31:2],2'b00}; FSM leaves FAILED.
  - If a request is pending without grant, it completes at its old address and its response is dropped. The new address is presented only after that grant.
- Wrap-around: the address increments modulo 2^32, so 32'hFFFF_FFFC is followed by 32'h0000_0000.
- The outstanding and drop counters saturate logically at DEPTH; assertions flag any excess.
- fetch_failed_o is valid only with fetch_valid_o. The IF stage uses it to set its fetch-failed flag; entries after an error never exist.

Test Plan:
- Reset then fetch_enable_i=1, gnt always 1, rvalid one cycle after gnt with data 32'h1000_0013 + n → requests at 0x80, 0x84, …; fetch_valid_o 1 cycle after each rvalid, with fetch_addr_o matching; fetch_ready_i=0 stalls issue after DEPTH=2 transactions.
- Backpressure: fetch_ready_i=0 for 10 cycles → exactly 2 FIFO entries, no third instr_req_o; raising fetch_ready_i → entries pop in order and requests resume at 0x88.
- Branch with 2 outstanding (branch_addr_i=0x0000_0203) → both late responses dropped, FIFO empty the next cycle, next request at 0x200, first delivered fetch_addr_o=0x200.
- Branch while instr_req_o=1 and gnt=0 for 3 cycles → instr_addr_o stays at the old address until gnt; that response is dropped, then the request at the branch target follows.
- instr_err_i=1 on response at 0x84 → entry 0x84 has fetch_failed_o=1, no further requests; branch_i to 0x400 → FAILED exits and fetching resumes at 0x400.
- Branch to 0xFFFF_FFF8 → fetch addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; assert rst_n=0 mid-burst → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/cv32e40p_fetch_sequencer.sv
// Instruction fetch sequencer: issues word fetches on an OBI-style port,
// tracks outstanding transactions, buffers responses in a small FIFO for
// the IF stage, drops stale responses after a redirect and parks after a
// bus error until the next redirect.

module cv32e40p_fetch_sequencer #(
  parameter int          DEPTH     = 2,
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_enable_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  input  logic        fetch_ready_i,
  output logic        fetch_valid_o,
  output logic [31:0] fetch_rdata_o,
  output logic [31:0] fetch_addr_o,
  output logic        fetch_failed_o,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i,
  output logic        busy_o
);

  localparam logic [2:0] DEP  = 3'(DEPTH);
  localparam logic [1:0] LAST = 2'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_FAILED = 2'd2
  } state_e;

  // Circular pointer advance; storage is sized for the largest DEPTH.
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == LAST) ? 2'd0 : p + 2'd1;
  endfunction

  // Clamp a counter update at DEPTH.
  function automatic logic [2:0] sat(input logic [3:0] v);
    return (v > {1'b0, DEP}) ? DEP : v[2:0];
  endfunction

  state_e      r_state, w_state_nxt;
  logic [31:0] r_addr, w_addr_nxt;
  logic [31:0] r_pend_addr, w_pend_addr_nxt;
  logic        r_pend, w_pend_nxt;     // redirect waiting for the pending grant
  logic        r_kill, w_kill_nxt;     // pending request's response is stale
  logic        r_failed, w_failed_nxt;
  logic [2:0]  r_out, w_out_nxt;
  logic [2:0]  r_drop, w_drop_nxt;
  logic [2:0]  r_cnt, w_cnt_nxt;
  logic [3:0]  w_out_raw, w_drop_raw, w_sum;
  logic        w_budget_ok;

  logic [31:0] r_aq [4];               // issue-order address queue
  logic [1:0]  r_aq_wr, r_aq_rd;
  logic [31:0] r_fd [4];
  logic [31:0] r_fa [4];
  logic        r_fe [4];
  logic [1:0]  r_f_wr, r_f_rd;

  logic        w_gnt, w_rv, w_dropping, w_push, w_err_push, w_pop;
  logic [31:0] w_target;

  assign w_gnt      = (r_state == S_ISSUE) & instr_gnt_i;
  assign w_rv       = instr_rvalid_i & (r_out != 3'd0);
  assign w_dropping = w_rv & (r_drop != 3'd0);
  assign w_push     = w_rv & ~w_dropping & ~branch_i;
  assign w_err_push = w_push & instr_err_i;
  assign w_pop      = (r_cnt != 3'd0) & fetch_ready_i & ~branch_i;
  assign w_target   = branch_addr_i & 32'hFFFF_FFFC;

  assign w_out_raw  = {1'b0, r_out} + {3'b000, w_gnt} - {3'b000, w_rv};
  assign w_out_nxt  = sat(w_out_raw);
  assign w_drop_raw = {1'b0, r_drop} - {3'b000, w_dropping} + {3'b000, w_gnt & r_kill};

  // Next-state, address, counter and redirect bookkeeping.
  always_comb begin
    w_state_nxt     = r_state;
    w_addr_nxt      = r_addr;
    w_pend_nxt      = r_pend;
    w_pend_addr_nxt = r_pend_addr;
    w_kill_nxt      = r_kill;
    w_failed_nxt    = r_failed;
    w_drop_nxt      = r_drop;
    w_cnt_nxt       = r_cnt;
    w_sum           = 4'd0;
    w_budget_ok     = 1'b0;

    if (branch_i) begin
      // Every response still in flight (including this cycle's grant) is stale.
      w_drop_nxt   = w_out_nxt;
      w_cnt_nxt    = 3'd0;
      w_failed_nxt = 1'b0;
      if ((r_state == S_ISSUE) && !instr_gnt_i) begin
        // Let the ungranted request finish at its old address, then redirect.
        w_pend_nxt      = 1'b1;
        w_pend_addr_nxt = w_target;
        w_kill_nxt      = 1'b1;
      end else begin
        w_addr_nxt = w_target;
        w_pend_nxt = 1'b0;
        w_kill_nxt = 1'b0;
      end
    end else begin
      if (w_err_push) begin
        // Nothing after the failed entry may reach the FIFO.
        w_drop_nxt   = w_out_nxt;
        w_failed_nxt = 1'b1;
      end else begin
        w_drop_nxt = sat(w_drop_raw);
      end
      w_cnt_nxt = r_cnt + {2'b00, w_push} - {2'b00, w_pop};
      if (w_gnt) begin
        w_addr_nxt = r_pend ? r_pend_addr : r_addr + 32'd4;
        w_pend_nxt = 1'b0;
        w_kill_nxt = 1'b0;
      end else if (w_err_push && (r_state == S_ISSUE)) begin
        w_kill_nxt = 1'b1;
      end else begin
        w_kill_nxt = r_kill;
      end
    end

    w_sum       = {1'b0, w_out_nxt} + {1'b0, w_cnt_nxt};
    w_budget_ok = (w_sum < {1'b0, DEP});

    case (r_state)
      S_ISSUE: begin
        if (!instr_gnt_i) begin
          w_state_nxt = S_ISSUE;
        end else if (w_failed_nxt) begin
          w_state_nxt = S_FAILED;
        end else if (fetch_enable_i && w_budget_ok) begin
          w_state_nxt = S_ISSUE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        if (w_failed_nxt) begin
          w_state_nxt = S_FAILED;
        end else if (fetch_enable_i && w_budget_ok) begin
          w_state_nxt = S_ISSUE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
    endcase
  end

  // Control state and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_addr      <= BOOT_ADDR;
      r_pend      <= 1'b0;
      r_pend_addr <= 32'h0000_0000;
      r_kill      <= 1'b0;
      r_failed    <= 1'b0;
      r_out       <= 3'd0;
      r_drop      <= 3'd0;
      r_cnt       <= 3'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_addr      <= w_addr_nxt;
      r_pend      <= w_pend_nxt;
      r_pend_addr <= w_pend_addr_nxt;
      r_kill      <= w_kill_nxt;
      r_failed    <= w_failed_nxt;
      r_out       <= w_out_nxt;
      r_drop      <= w_drop_nxt;
      r_cnt       <= w_cnt_nxt;
    end
  end

  // Queue pointers; the address queue survives redirects, the FIFO does not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aq_wr <= 2'd0;
      r_aq_rd <= 2'd0;
      r_f_wr  <= 2'd0;
      r_f_rd  <= 2'd0;
    end else begin
      if (w_gnt) r_aq_wr <= ptr_inc(r_aq_wr);
      if (w_rv)  r_aq_rd <= ptr_inc(r_aq_rd);
      if (branch_i) begin
        r_f_wr <= 2'd0;
        r_f_rd <= 2'd0;
      end else begin
        if (w_push) r_f_wr <= ptr_inc(r_f_wr);
        if (w_pop)  r_f_rd <= ptr_inc(r_f_rd);
      end
    end
  end

  // Queue storage (data only, no reset needed).
  always_ff @(posedge clk) begin
    if (w_gnt) r_aq[r_aq_wr] <= r_addr;
    if (w_push) begin
      r_fd[r_f_wr] <= instr_rdata_i;
      r_fa[r_f_wr] <= r_aq[r_aq_rd];
      r_fe[r_f_wr] <= instr_err_i;
    end
  end

  assign fetch_valid_o  = (r_cnt != 3'd0);
  assign fetch_rdata_o  = fetch_valid_o ? r_fd[r_f_rd] : 32'h0000_0000;
  assign fetch_addr_o   = fetch_valid_o ? r_fa[r_f_rd] : 32'h0000_0000;
  assign fetch_failed_o = fetch_valid_o & r_fe[r_f_rd];
  assign instr_req_o    = (r_state == S_ISSUE);
  assign instr_addr_o   = r_addr;
  assign busy_o         = (r_out != 3'd0) | instr_req_o;

  cv32e40p_fetch_sequencer_chk #(.DEPTH(DEPTH)) u_chk (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_out    (r_out),
    .i_drop   (r_drop),
    .i_cnt    (r_cnt),
    .i_out_raw(w_out_raw),
    .i_push   (w_push),
    .i_pop    (w_pop)
  );

endmodule

// Invariant checker for the fetch sequencer counters and FIFO.
module cv32e40p_fetch_sequencer_chk #(
  parameter int DEPTH = 2
) (
  input logic       clk,
  input logic       rst_n,
  input logic [2:0] i_out,
  input logic [2:0] i_drop,
  input logic [2:0] i_cnt,
  input logic [3:0] i_out_raw,
  input logic       i_push,
  input logic       i_pop
);
  localparam logic [2:0] DEP = 3'(DEPTH);

  // Flag FIFO overflow and counter excess.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(i_push && !i_pop && (i_cnt == DEP)));
      assert (i_out_raw <= {1'b0, DEP});
      assert (i_drop <= i_out);
    end
  end
endmodule
